// File: rtl/wb_regfile.sv
// wb_regfile -- write-back stage and architectural register file.
//
// Selects the write-back value (load data or ALU result) and commits it to
// an NREGS-entry register file with r0 hardwired to zero. It serves two
// combinational read ports with same-cycle write-through bypass, registers
// the committed write for forwarding to EX, and counts retired writes.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   w_write_reg_i       commit this instruction's result
//   w_mem_to_reg_i      1 = write back data_from_mem, 0 = alu_result_i
//   data_from_mem       loaded data from MEM
//   alu_result_i        ALU result from MEM
//   w_des_r_i           destination register
//   raddr1/raddr2       ID-stage read addresses
//   rdata1/rdata2       combinational read data
//   wb_write_reg_o      registered effective write enable
//   wb_des_r_o          registered destination
//   wb_data_o           registered write-back value
//   wb_count_o          committed-write count (wraps)

// One read port: r0 and reset force zero, otherwise bypass the in-flight
// write when it targets the same register, else read the array.
module wb_rf_rdport #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREGS  = 32
) (
  input  logic                          rst,
  input  logic [ADDR_W-1:0]             raddr_i,
  input  logic                          we_i,
  input  logic [ADDR_W-1:0]             wdes_i,
  input  logic [DATA_W-1:0]             wdata_i,
  input  logic [NREGS-1:0][DATA_W-1:0]  regs_i,
  output logic [DATA_W-1:0]             rdata_o
);
  always_comb begin
    rdata_o = '0;
    if (rst || raddr_i == '0)
      rdata_o = '0;
    else if (we_i && raddr_i == wdes_i)
      rdata_o = wdata_i;
    else
      rdata_o = regs_i[raddr_i];
  end
endmodule

module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_write_reg_i,
  input  logic              w_mem_to_reg_i,
  input  logic [DATA_W-1:0] data_from_mem,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [ADDR_W-1:0] w_des_r_i,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              wb_write_reg_o,
  output logic [ADDR_W-1:0] wb_des_r_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic [31:0]       wb_count_o
);
  localparam int NUM_RD = 2;

  logic [DATA_W-1:0]            wb_data;
  logic                         we;
  logic [NREGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [31:0]                  cnt_q, cnt_d;
  logic                         fwd_we_q;
  logic [ADDR_W-1:0]            fwd_des_q;
  logic [DATA_W-1:0]            fwd_data_q;

  logic [NUM_RD-1:0][ADDR_W-1:0] raddr;
  logic [NUM_RD-1:0][DATA_W-1:0] rdata;

  assign wb_data = w_mem_to_reg_i ? data_from_mem : alu_result_i;
  // Writes to r0 are dropped here so they neither commit nor count.
  assign we      = w_write_reg_i && (w_des_r_i != '0) && !rst;

  always_comb begin
    regs_d = regs_q;
    if (we)
      regs_d[w_des_r_i] = wb_data;
    regs_d[0] = '0;
  end

  assign cnt_d = we ? cnt_q + 32'd1 : cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q     <= '0;
      cnt_q      <= '0;
      fwd_we_q   <= 1'b0;
      fwd_des_q  <= '0;
      fwd_data_q <= '0;
    end else begin
      regs_q     <= regs_d;
      cnt_q      <= cnt_d;
      fwd_we_q   <= we;
      fwd_des_q  <= w_des_r_i;
      fwd_data_q <= wb_data;
    end
  end

  assign raddr = {raddr2, raddr1};

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    wb_rf_rdport #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NREGS  (NREGS)
    ) u_rd (
      .rst     (rst),
      .raddr_i (raddr[p]),
      .we_i    (we),
      .wdes_i  (w_des_r_i),
      .wdata_i (wb_data),
      .regs_i  (regs_q),
      .rdata_o (rdata[p])
    );
  end

  assign rdata1         = rdata[0];
  assign rdata2         = rdata[1];
  assign wb_write_reg_o = fwd_we_q;
  assign wb_des_r_o     = fwd_des_q;
  assign wb_data_o      = fwd_data_q;
  assign wb_count_o     = cnt_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile. Inputs change 1 ns after posedge;
// combinational reads are checked 2 ns after posedge, registered outputs
// are checked after the following posedge.
module tb_wb_regfile;
  logic        clk = 1'b0;
  logic        rst;
  logic        w_write_reg_i, w_mem_to_reg_i;
  logic [31:0] data_from_mem, alu_result_i;
  logic [4:0]  w_des_r_i, raddr1, raddr2;
  logic [31:0] rdata1, rdata2, wb_data_o, wb_count_o;
  logic        wb_write_reg_o;
  logic [4:0]  wb_des_r_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk            (clk),
    .rst            (rst),
    .w_write_reg_i  (w_write_reg_i),
    .w_mem_to_reg_i (w_mem_to_reg_i),
    .data_from_mem  (data_from_mem),
    .alu_result_i   (alu_result_i),
    .w_des_r_i      (w_des_r_i),
    .raddr1         (raddr1),
    .raddr2         (raddr2),
    .rdata1         (rdata1),
    .rdata2         (rdata2),
    .wb_write_reg_o (wb_write_reg_o),
    .wb_des_r_o     (wb_des_r_o),
    .wb_data_o      (wb_data_o),
    .wb_count_o     (wb_count_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to 1 ns after the next posedge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic m2r, input logic [31:0] mem,
                       input logic [31:0] alu, input logic [4:0] des);
    w_write_reg_i  = wr;
    w_mem_to_reg_i = m2r;
    data_from_mem  = mem;
    alu_result_i   = alu;
    w_des_r_i      = des;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 1'b0, 32'h0, 32'h55, 5'd5);
    raddr1 = 5'd5;
    raddr2 = 5'd5;
    step();
    step();
    #1;
    // Reset held with a write pending: nothing reads through, outputs zero.
    chk("rst_rdata1", rdata1, 32'h0);
    chk("rst_rdata2", rdata2, 32'h0);
    chk("rst_wbwe", {31'h0, wb_write_reg_o}, 32'h0);
    chk("rst_wbdes", {27'h0, wb_des_r_o}, 32'h0);
    chk("rst_wbdata", wb_data_o, 32'h0);
    chk("rst_cnt", wb_count_o, 32'h0);

    // ALU write to r5: bypass same cycle, array next cycle.
    rst = 1'b0;
    drive(1'b1, 1'b0, 32'h0, 32'h0000_1234, 5'd5);
    #1;
    chk("r5_bypass", rdata1, 32'h1234);
    step();
    idle();
    #1;
    chk("r5_array", rdata1, 32'h1234);
    chk("r5_cnt", wb_count_o, 32'd1);
    chk("r5_wbwe", {31'h0, wb_write_reg_o}, 32'd1);
    chk("r5_wbdes", {27'h0, wb_des_r_o}, 32'd5);
    chk("r5_wbdata", wb_data_o, 32'h1234);

    // Load path to r7.
    raddr2 = 5'd7;
    drive(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h10, 5'd7);
    #1;
    chk("r7_bypass", rdata2, 32'hDEAD_BEEF);
    chk("r5_nobyp", rdata1, 32'h1234);
    step();
    idle();
    #1;
    chk("r7_array", rdata2, 32'hDEAD_BEEF);
    chk("r7_wbdata", wb_data_o, 32'hDEAD_BEEF);
    chk("r7_cnt", wb_count_o, 32'd2);

    // Write to r0 is discarded.
    raddr1 = 5'd0;
    drive(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 5'd0);
    #1;
    chk("r0_same", rdata1, 32'h0);
    step();
    idle();
    #1;
    chk("r0_next", rdata1, 32'h0);
    chk("r0_cnt", wb_count_o, 32'd2);
    chk("r0_wbwe", {31'h0, wb_write_reg_o}, 32'h0);

    // mem_to_reg without write enable does nothing.
    raddr1 = 5'd4;
    drive(1'b0, 1'b1, 32'h4444_4444, 32'h0, 5'd4);
    #1;
    chk("nowr_byp", rdata1, 32'h0);
    step();
    idle();
    #1;
    chk("nowr_arr", rdata1, 32'h0);
    chk("nowr_wbwe", {31'h0, wb_write_reg_o}, 32'h0);
    chk("nowr_cnt", wb_count_o, 32'd2);

    // Back-to-back writes to r3, both ports on r3.
    raddr1 = 5'd3;
    raddr2 = 5'd3;
    drive(1'b1, 1'b0, 32'h0, 32'hA, 5'd3);
    #1;
    chk("r3a_p1", rdata1, 32'hA);
    chk("r3a_p2", rdata2, 32'hA);
    step();
    drive(1'b1, 1'b0, 32'h0, 32'hB, 5'd3);
    #1;
    chk("r3b_p1", rdata1, 32'hB);
    chk("r3b_p2", rdata2, 32'hB);
    step();
    idle();
    #1;
    chk("r3c_p1", rdata1, 32'hB);
    chk("r3c_p2", rdata2, 32'hB);
    chk("r3_cnt", wb_count_o, 32'd4);

    // Fill r1..r31, then reset coincident with a write to r9.
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 1'b0, 32'h0, 32'h100 + i, i[4:0]);
      step();
    end
    idle();
    raddr1 = 5'd9;
    raddr2 = 5'd31;
    #1;
    chk("fill_r9", rdata1, 32'h109);
    chk("fill_r31", rdata2, 32'h11F);
    chk("fill_cnt", wb_count_o, 32'd35);
    rst = 1'b1;
    drive(1'b1, 1'b0, 32'h0, 32'hBAD, 5'd9);
    #1;
    chk("rst_mid_rd", rdata1, 32'h0);
    step();
    rst = 1'b0;
    idle();
    #1;
    chk("rst_mid_cnt", wb_count_o, 32'h0);
    chk("rst_mid_wbwe", {31'h0, wb_write_reg_o}, 32'h0);
    chk("rst_mid_wbdata", wb_data_o, 32'h0);
    for (int i = 0; i < 32; i++) begin
      raddr1 = i[4:0];
      #1;
      chk($sformatf("clr_r%0d", i), rdata1, 32'h0);
    end

    // Counter wrap: preload the counter to all-ones, then commit once.
    step();
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    #1;
    chk("wrap_pre", wb_count_o, 32'hFFFF_FFFF);
    step();
    raddr1 = 5'd2;
    drive(1'b1, 1'b0, 32'h0, 32'h77, 5'd2);
    step();
    idle();
    #1;
    chk("wrap_cnt", wb_count_o, 32'h0);
    chk("wrap_r2", rdata1, 32'h77);
    chk("wrap_wbwe", {31'h0, wb_write_reg_o}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and architectural register file for the five-stage pipeline. It takes the registered outputs of the MEM stage: write-enable, memory-to-reg select, loaded data, ALU result and destination register. It selects the write-back value, commits it to a 32-entry register file, and serves two combinational read ports to the ID stage with same-cycle write-through bypass. It also registers the committed write for forwarding to EX and keeps a retired-write counter for debug and verification.

## Interface
Parameters:
- `DATA_W`, default 32, register data width (matches `RegDataBus`).
- `ADDR_W`, default 5, register address width (matches `RegAddrBus`).
- `NREGS`, default 32, number of registers (2^`ADDR_W`).

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `w_write_reg_i`  in  1  commit this instruction's result.
- `w_mem_to_reg_i`  in  1  1 = write back `data_from_mem`; 0 = write back `alu_result_i`.
- `data_from_mem`  in  `DATA_W`  loaded data from MEM stage.
- `alu_result_i`  in  `DATA_W`  ALU result from MEM stage.
- `w_des_r_i`  in  `ADDR_W`  destination register.
- `raddr1`, `raddr2`  in  `ADDR_W`  ID-stage read addresses.
- `rdata1`, `rdata2`  out  `DATA_W`  combinational read data.
- `wb_write_reg_o`  out  1  registered copy of the effective write enable.
- `wb_des_r_o`  out  `ADDR_W`  registered destination.
- `wb_data_o`  out  `DATA_W`  registered write-back value.
- `wb_count_o`  out  32  count of committed writes.

## Operation
- Write-back value: `wb_data = w_mem_to_reg_i ? data_from_mem : alu_result_i`. This is combinational.
- Effective write enable: `we = w_write_reg_i & (w_des_r_i != 0) & ~rst`.
- Register 0 is hardwired to zero.
  - Writes to r0 are discarded.
  - Reads of r0 return 0.
  - A write to r0 does not increment `wb_count_o` and gives `wb_write_reg_o` = 0.
- On posedge with `we`: `regs[w_des_r_i] <= wb_data`, and `wb_count_o` increments by 1, wrapping from 0xFFFFFFFF to 0.
- Read port n (identical for both ports):
  - If `raddr_n == 0`, the port returns 0.
  - Otherwise, if `we` and `raddr_n == w_des_r_i`, the port returns `wb_data` (bypass).
  - Otherwise the port returns `regs[raddr_n]`.
- Both ports can read the same address in the same cycle, and both may bypass simultaneously.
- Forwarding register, updated every posedge:
  - `wb_write_reg_o <= we`
  - `wb_des_r_o <= w_des_r_i`
  - `wb_data_o <= wb_data`
- `wb_data_o` and `wb_des_r_o` are "don't care" when `wb_write_reg_o` = 0, but still update as specified.
- Reset: on any posedge with `rst` = 1:
  - All `NREGS` registers clear to 0.
  - `wb_count_o`, `wb_write_reg_o`, `wb_des_r_o` and `wb_data_o` clear to 0.
  - No write is committed, even if `w_write_reg_i` = 1.
- While `rst` = 1, `rdata1` and `rdata2` read 0 regardless of address or array contents.
- Reset asserted mid-stream wins over a simultaneous write. The first write after reset deasserts commits normally on the next posedge.

## Timing
- Commit latency: a MEM-stage output presented in cycle t is written at the posedge ending cycle t. It is visible through the array from cycle t+1 and through the bypass in cycle t itself.
- Read ports: zero-latency combinational path from `raddr_n`, `w_*` inputs and array contents.
- Forwarding outputs: valid in cycle t+1 for the write committed at the end of cycle t.
- `wb_count_o` reflects a commit from cycle t+1.
- Back-to-back writes to the same register: the last write wins. A read in the same cycle as the second write sees the second write's value via bypass.
- `w_mem_to_reg_i` = 1 with `w_write_reg_i` = 0: nothing is written, and `wb_write_reg_o` = 0 next cycle.
- Reset values of all outputs:
  - `rdata1`/`rdata2` = 0 while in reset.
  - `wb_write_reg_o` = 0, `wb_des_r_o` = 0, `wb_data_o` = 0, `wb_count_o` = 0.

## Test plan
- Reset, then write r5 with ALU 0x0000_1234: `raddr1`=5 reads 0x1234 in the same cycle (bypass) and the next cycle (array); `wb_count_o`=1 and `wb_write_reg_o`=1 the following cycle.
- Load path: `w_mem_to_reg_i`=1, `data_from_mem`=0xDEAD_BEEF, `alu_result_i`=0x10, dest r7: r7 reads 0xDEADBEEF and `wb_data_o`=0xDEADBEEF next cycle.
- Write r0 with 0xFFFF_FFFF: `rdata1` with `raddr1`=0 reads 0 the same and next cycle; `wb_count_o` is unchanged; `wb_write_reg_o`=0.
- Same-address dual read during a write: write r3=0xA, then r3=0xB on consecutive cycles with `raddr1`=`raddr2`=3. Both ports read 0xA in cycle 1, then 0xB in cycle 2 and afterwards.
- Reset mid-operation: fill r1..r31 with 0x100+i, then assert `rst` coincident with a write to r9. After reset every register reads 0, r9 was not written, and `wb_count_o`=0.
- Counter wrap: force 2^32 commits (or preload via a bench hierarchy force to 0xFFFFFFFF), then one more write to r2: `wb_count_o`=0.
